signed_fadd_overflow: RTL and testbench

SIGNED_FADD_OVERFLOW -- requirements
Module: signed_fadd_overflow

---
 rtl/signed_fadd_overflow.sv | 55 +++++
 tb/tb_signed_fadd_overflow.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/signed_fadd_overflow.sv
// Ripple-carry two's-complement adder with signed-overflow detection,
// a registered copy of its results and a sticky overflow flag.
module signed_fadd_overflow #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             clr_sticky,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
   output logic             overflow_q,
   output logic             ovf_sticky
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   // One full-adder cell per bit; carry[i] is the carry into bit i.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic half;
      assign half       = a[i] ^ b[i];
      assign sum[i]     = half ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & half);
   end

   // Signed overflow: the carry into the sign bit disagrees with the carry out of it.
   assign cout     = carry[WIDTH];
   assign overflow = carry[WIDTH-1] ^ carry[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q      <= '0;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         sum_q      <= sum;
         cout_q     <= cout;
         overflow_q <= overflow;
         // A clear still captures an overflow seen in the same cycle.
         if (clr_sticky)
            ovf_sticky <= overflow;
         else
            ovf_sticky <= ovf_sticky | overflow;
      end
   end

endmodule

// File: tb/tb_signed_fadd_overflow.sv
// Directed self-checking bench for signed_fadd_overflow: combinational
// results, registered path, sticky flag set/clear priority and async reset.
module tb_signed_fadd_overflow;

   localparam int WIDTH = 8;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             clr_sticky;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             overflow_q;
   logic             ovf_sticky;

   int vectors = 0;
   int errors  = 0;

   signed_fadd_overflow #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .cin        (cin),
      .clr_sticky (clr_sticky),
      .sum        (sum),
      .cout       (cout),
      .overflow   (overflow),
      .sum_q      (sum_q),
      .cout_q     (cout_q),
      .overflow_q (overflow_q),
      .ovf_sticky (ovf_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; a = 8'h7F; b = 8'h40; cin = 1'b0; clr_sticky = 1'b0;
      #2;
      vectors++;
      if ({sum_q, cout_q, overflow_q, ovf_sticky} !== 11'd0) begin
         errors++;
         $display("[TB] FAIL reset_regs: got sum_q=%h cout_q=%b ovf_q=%b sticky=%b, expected all 0",
                  sum_q, cout_q, overflow_q, ovf_sticky);
      end
      vectors++;
      if ({sum, cout, overflow} !== {8'hBF, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL reset_comb: got sum=%h cout=%b ovf=%b, expected BF/0/1", sum, cout, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_combinational();
      vec_t tbl[14];
      tbl = '{
         '{8'h0F, 8'h70, 1'b0, 8'h7F, 1'b0, 1'b0},
         '{8'h7F, 8'h40, 1'b0, 8'hBF, 1'b0, 1'b1},
         '{8'h81, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0},
         '{8'h80, 8'h81, 1'b0, 8'h01, 1'b1, 1'b1},
         '{8'h7E, 8'h81, 1'b0, 8'hFF, 1'b0, 1'b0},
         '{8'h7F, 8'h81, 1'b0, 8'h00, 1'b1, 1'b0},
         '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
         '{8'h00, 8'h0F, 1'b0, 8'h0F, 1'b0, 1'b0},
         '{8'h00, 8'hF0, 1'b0, 8'hF0, 1'b0, 1'b0},
         '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0},
         '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1},
         '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
         '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
         '{8'h55, 8'h2A, 1'b1, 8'h80, 1'b0, 1'b1}
      };
      foreach (tbl[i]) begin
         a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin;
         #1;
         vectors++;
         if ({sum, cout, overflow} !== {tbl[i].s, tbl[i].co, tbl[i].ov}) begin
            errors++;
            $display("[TB] FAIL comb[%0d] %h+%h+%b: got sum=%h cout=%b ovf=%b, expected %h/%b/%b",
                     i, tbl[i].a, tbl[i].b, tbl[i].cin, sum, cout, overflow,
                     tbl[i].s, tbl[i].co, tbl[i].ov);
         end
      end
   endtask

   task automatic test_opposite_sign();
      vec_t tbl[4];
      tbl = '{
         '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0},
         '{8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b0},
         '{8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b1, 1'b0},
         '{8'h01, 8'h80, 1'b0, 8'h81, 1'b0, 1'b0}
      };
      foreach (tbl[i]) begin
         a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin;
         #1;
         vectors++;
         if ({sum, cout, overflow} !== {tbl[i].s, tbl[i].co, tbl[i].ov}) begin
            errors++;
            $display("[TB] FAIL opp_sign[%0d] %h+%h+%b: got sum=%h cout=%b ovf=%b, expected %h/%b/%b",
                     i, tbl[i].a, tbl[i].b, tbl[i].cin, sum, cout, overflow,
                     tbl[i].s, tbl[i].co, tbl[i].ov);
         end
      end
   endtask

   task automatic test_registered_sticky();
      @(negedge clk);
      a = 8'h7F; b = 8'h40; cin = 1'b0; clr_sticky = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({sum_q, cout_q, overflow_q, ovf_sticky} !== {8'hBF, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("[TB] FAIL reg_ovf: got sum_q=%h cout_q=%b ovf_q=%b sticky=%b, expected BF/0/1/1",
                  sum_q, cout_q, overflow_q, ovf_sticky);
      end
      a = 8'h00; b = 8'h00;
      @(posedge clk); #1;
      vectors++;
      if ({sum_q, cout_q, overflow_q, ovf_sticky} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL reg_hold: got sum_q=%h cout_q=%b ovf_q=%b sticky=%b, expected 00/0/0/1",
                  sum_q, cout_q, overflow_q, ovf_sticky);
      end
      clr_sticky = 1'b1;
      @(posedge clk); #1;
      clr_sticky = 1'b0;
      vectors++;
      if (ovf_sticky !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sticky_clear: got sticky=%b, expected 0", ovf_sticky);
      end
      @(posedge clk); #1;
      vectors++;
      if (ovf_sticky !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sticky_stays_clear: got sticky=%b, expected 0", ovf_sticky);
      end
      // clear and overflow together: set wins
      a = 8'h80; b = 8'h81; clr_sticky = 1'b1;
      @(posedge clk); #1;
      clr_sticky = 1'b0;
      vectors++;
      if ({sum_q, cout_q, overflow_q, ovf_sticky} !== {8'h01, 1'b1, 1'b1, 1'b1}) begin
         errors++;
         $display("[TB] FAIL sticky_set_priority: got sum_q=%h cout_q=%b ovf_q=%b sticky=%b, expected 01/1/1/1",
                  sum_q, cout_q, overflow_q, ovf_sticky);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] av[4] = '{8'h10, 8'hF0, 8'h40, 8'hC0};
      logic [7:0] bv[4] = '{8'h20, 8'h20, 8'h40, 8'hC0};
      logic [9:0] ev[4] = '{{8'h30, 1'b0, 1'b0}, {8'h10, 1'b1, 1'b0},
                             {8'h80, 1'b0, 1'b1}, {8'h80, 1'b1, 1'b0}};
      cin = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = av[i]; b = bv[i];
         @(posedge clk); #1;
         vectors++;
         if ({sum_q, cout_q, overflow_q} !== ev[i]) begin
            errors++;
            $display("[TB] FAIL b2b[%0d]: got sum_q=%h cout_q=%b ovf_q=%b, expected %h/%b/%b",
                     i, sum_q, cout_q, overflow_q, ev[i][9:2], ev[i][1], ev[i][0]);
         end
      end
      vectors++;
      if (ovf_sticky !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_sticky: got sticky=%b, expected 1", ovf_sticky);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({sum_q, cout_q, overflow_q, ovf_sticky} !== 11'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: got sum_q=%h cout_q=%b ovf_q=%b sticky=%b, expected all 0",
                  sum_q, cout_q, overflow_q, ovf_sticky);
      end
      a = 8'hF0; b = 8'h0F; cin = 1'b1;
      #1;
      vectors++;
      if ({sum, cout, overflow} !== {8'h00, 1'b1, 1'b0}) begin
         errors++;
         $display("[TB] FAIL reset_comb_track: got sum=%h cout=%b ovf=%b, expected 00/1/0", sum, cout, overflow);
      end
      a = 8'h7F; b = 8'h40; cin = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({sum_q, cout_q, overflow_q, ovf_sticky} !== 11'd0) begin
         errors++;
         $display("[TB] FAIL reset_hold: got sum_q=%h cout_q=%b ovf_q=%b sticky=%b, expected all 0",
                  sum_q, cout_q, overflow_q, ovf_sticky);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({sum_q, cout_q, overflow_q, ovf_sticky} !== {8'hBF, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("[TB] FAIL reset_resume: got sum_q=%h cout_q=%b ovf_q=%b sticky=%b, expected BF/0/1/1",
                  sum_q, cout_q, overflow_q, ovf_sticky);
      end
   endtask

   initial begin
      test_reset();
      test_combinational();
      test_opposite_sign();
      test_registered_sticky();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
